// File: rtl/prime_pkg.sv
// Shared types and helpers for the prime generator datapath.
package prime_pkg;

    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned MAX_CW    = MAX_WIDTH + 1;
    localparam int unsigned SQ_W      = 2 * MAX_CW;

    localparam logic PRIME     = 1'b1;
    localparam logic NOT_PRIME = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        NEXT,
        DIV_GO,
        DIV_WAIT,
        EMIT,
        FIN
    } state_t;

    // True while d*d <= cand, i.e. d is still a useful trial divisor.
    function automatic logic isqrt_ok(input logic [MAX_CW-1:0] d,
                                      input logic [MAX_CW-1:0] cand);
        logic [SQ_W-1:0] sq;
        sq = SQ_W'(d) * SQ_W'(d);
        return sq <= SQ_W'(cand);
    endfunction

endpackage

// File: rtl/prime_mod_unit.sv
// Iterative restoring shift-subtract remainder unit; one quotient bit per cycle.
module prime_mod_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mod_start,
    input  logic [WIDTH:0] dividend,
    input  logic [WIDTH:0] divisor,
    output logic           mod_done,
    output logic [WIDTH:0] remainder
);

    localparam int unsigned N     = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [N-1:0]     quo;
    logic [N-1:0]     dsr;
    logic [CNT_W-1:0] cnt;
    logic [N:0]       shifted;
    logic [N:0]       diff;
    logic             ge;
    logic [N-1:0]     rem_step;

    // A zero divisor always "fits", so the dividend bits pass straight through.
    always_comb begin
        shifted  = {remainder, quo[N-1]};
        diff     = shifted - {1'b0, dsr};
        ge       = shifted >= {1'b0, dsr};
        rem_step = ge ? diff[N-1:0] : shifted[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remainder <= '0;
            quo       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            mod_done  <= 1'b0;
        end else begin
            mod_done <= 1'b0;
            if (mod_start) begin
                remainder <= '0;
                quo       <= dividend;
                dsr       <= divisor;
                cnt       <= CNT_W'(N);
            end else if (cnt != '0) begin
                remainder <= rem_step;
                quo       <= {quo[N-2:0], 1'b0};
                cnt       <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    mod_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prime_generator.sv
// Streams the primes in [2, limit] in ascending order using trial division.
module prime_generator
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out_prime,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   prime_cnt,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = WIDTH + 1;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cand;
    logic [CW-1:0]  d;
    logic [CW-1:0]  d_next;
    logic [WIDTH-1:0] lim_q;
    logic [CW-1:0]  remainder;
    logic           mod_done;
    logic           root_ok;
    logic           xfer;

    // Control strobes decoded from the state
    logic           load;
    logic           mod_start;
    logic           d_init;
    logic           d_inc;
    logic           cand_inc;
    logic           emit_set;
    logic           fin;

    assign xfer    = out_valid && out_ready;
    assign d_next  = d + CW'(1);
    assign root_ok = isqrt_ok(MAX_CW'(d_next), MAX_CW'(cand));

    prime_mod_unit #(.WIDTH(WIDTH)) u_mod (
        .clk       (clk),
        .rst_n     (rst_n),
        .mod_start (mod_start),
        .dividend  (cand),
        .divisor   (d),
        .mod_done  (mod_done),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = (limit < WIDTH'(2)) ? FIN : NEXT;
            NEXT: begin
                if (cand > {1'b0, lim_q})   state_n = FIN;
                else if (cand < CW'(4))     state_n = EMIT;
                else                        state_n = DIV_GO;
            end
            DIV_GO:   state_n = DIV_WAIT;
            DIV_WAIT: begin
                if (mod_done) begin
                    if (remainder == '0)    state_n = NEXT;
                    else if (!root_ok)      state_n = EMIT;
                    else                    state_n = DIV_GO;
                end
            end
            EMIT:     if (xfer) state_n = NEXT;
            FIN:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        load      = (state == IDLE) && start;
        mod_start = (state == DIV_GO);
        d_init    = (state == NEXT);
        d_inc     = (state == DIV_WAIT) && mod_done && (remainder != '0);
        cand_inc  = ((state == DIV_WAIT) && mod_done && (remainder == '0))
                  || ((state == EMIT) && xfer);
        emit_set  = (state == EMIT) && !out_valid;
        fin       = (state == FIN);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand      <= '0;
            d         <= '0;
            lim_q     <= '0;
            out_prime <= '0;
            out_valid <= 1'b0;
            prime_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                lim_q     <= limit;
                cand      <= CW'(2);
                prime_cnt <= '0;
                busy      <= 1'b1;
            end
            if (d_init)   d    <= CW'(2);
            if (d_inc)    d    <= d_next;
            if (cand_inc) cand <= cand + CW'(1);
            if (emit_set) begin
                out_prime <= cand[WIDTH-1:0];
                out_valid <= 1'b1;
            end
            if (xfer) begin
                out_valid <= 1'b0;
                prime_cnt <= prime_cnt + CW'(1);
            end
            if (fin) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prime_generator.sv
// Directed, table-driven bench for prime_generator with a brute-force prime model.
module tb_prime_generator;
    import prime_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out_prime;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   prime_cnt;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;
    int got[$];
    int exp_q[$];

    typedef struct {
        int lim;
        int exp_cnt;
        int exp_last;
        int restart_at;
    } vec_t;

    vec_t vecs[10];

    prime_generator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .limit     (limit),
        .out_prime (out_prime),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prime_cnt (prime_cnt),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic check_prime(input int n);
        if (n < 2) return NOT_PRIME;
        for (int k = 2; k < n; k++) begin
            if (n % k == 0) return NOT_PRIME;
        end
        return PRIME;
    endfunction

    task automatic build_expected(input int lim);
        exp_q.delete();
        for (int i = 0; i <= lim; i++) begin
            if (check_prime(i) == PRIME) exp_q.push_back(i);
        end
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_prime%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    // Start a run and collect transfers until done; restart_at>=0 pulses a stray start.
    task automatic run_collect(input int lim, input int restart_at,
                               output int dones, output int done_at,
                               output int first_valid_at, output int late_valid);
        bit finished;
        got.delete();
        dones = 0; done_at = -1; first_valid_at = -1; late_valid = 0;
        finished = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        limit = WIDTH'(lim);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 30000 && !finished; n++) begin
            if (n == restart_at) begin
                start = 1'b1;
                limit = WIDTH'(3);
            end else begin
                start = 1'b0;
            end
            if (out_valid && first_valid_at < 0) first_valid_at = n;
            if (out_valid && out_ready) got.push_back(int'(out_prime));
            if (done) begin
                dones++;
                done_at  = n;
                finished = 1'b1;
                check("busy_at_done", int'(busy), 0);
            end
            if (!finished) @(negedge clk);
        end
        start = 1'b0;
        if (!finished) check("run_timeout", 0, 1);
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
            if (out_valid) late_valid++;
        end
    endtask

    initial begin
        int dones, done_at, first_valid_at, late_valid, prev_last;
        bit found, stalled;

        vecs[0] = '{lim: 10,  exp_cnt: 4,  exp_last: 7,   restart_at: -1};
        vecs[1] = '{lim: 1,   exp_cnt: 0,  exp_last: 0,   restart_at: -1};
        vecs[2] = '{lim: 0,   exp_cnt: 0,  exp_last: 0,   restart_at: -1};
        vecs[3] = '{lim: 2,   exp_cnt: 1,  exp_last: 2,   restart_at: -1};
        vecs[4] = '{lim: 3,   exp_cnt: 2,  exp_last: 3,   restart_at: -1};
        vecs[5] = '{lim: 4,   exp_cnt: 2,  exp_last: 3,   restart_at: -1};
        vecs[6] = '{lim: 13,  exp_cnt: 6,  exp_last: 13,  restart_at: -1};
        vecs[7] = '{lim: 30,  exp_cnt: 10, exp_last: 29,  restart_at: 5};
        vecs[8] = '{lim: 20,  exp_cnt: 8,  exp_last: 19,  restart_at: -1};
        vecs[9] = '{lim: 255, exp_cnt: 54, exp_last: 251, restart_at: -1};

        rst_n = 1'b0; start = 1'b0; limit = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_prime", int'(out_prime), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_prime_cnt", int'(prime_cnt), 0);
        check("rst_busy",      int'(busy),      0);
        check("rst_done",      int'(done),      0);
        rst_n = 1'b1;
        @(negedge clk);

        prev_last = 0;
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("lim%0d", vecs[i].lim);
            run_collect(vecs[i].lim, vecs[i].restart_at, dones, done_at, first_valid_at, late_valid);
            build_expected(vecs[i].lim);
            check({tag, "_model_cnt"}, exp_q.size(), vecs[i].exp_cnt);
            compare_stream(tag);
            check({tag, "_prime_cnt"}, int'(prime_cnt), vecs[i].exp_cnt);
            check({tag, "_dones"}, dones, 1);
            check({tag, "_late_valid"}, late_valid, 0);
            check({tag, "_busy_end"}, int'(busy), 0);
            if (vecs[i].exp_cnt == 0) begin
                check({tag, "_done_latency"}, done_at, 1);
                check({tag, "_no_valid"}, first_valid_at, -1);
                check({tag, "_prime_kept"}, int'(out_prime), prev_last);
            end else begin
                check({tag, "_first_valid_latency"}, first_valid_at, 2);
                check({tag, "_last"}, int'(out_prime), vecs[i].exp_last);
                prev_last = vecs[i].exp_last;
            end
        end

        // Backpressure: hold ready low for 6 cycles while 5 is presented.
        got.delete();
        stalled = 1'b0; found = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1; limit = WIDTH'(20);
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 30000 && !found; n++) begin
            if (out_valid && out_prime == WIDTH'(5) && !stalled) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_prime", int'(out_prime), 5);
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) got.push_back(int'(out_prime));
            if (done) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check("stall_timeout", 0, 1);
        build_expected(20);
        compare_stream("stall");
        check("stall_prime_cnt", int'(prime_cnt), 8);

        // Reset mid-division at cand=9, then restart cleanly.
        found = 1'b0;
        @(negedge clk); start = 1'b1; limit = WIDTH'(20);
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            if (dut.state == DIV_WAIT && int'(dut.cand) == 9) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_div_wait_9", int'(found), 1);
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_cnt", int'(prime_cnt), 4);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_prime", int'(out_prime), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_prime_cnt", int'(prime_cnt), 0);
        check("midrst_busy",      int'(busy),      0);
        check("midrst_done",      int'(done),      0);
        check("midrst_state",     int'(dut.state), int'(IDLE));
        rst_n = 1'b1;
        run_collect(5, -1, dones, done_at, first_valid_at, late_valid);
        build_expected(5);
        compare_stream("after_rst");
        check("after_rst_dones", dones, 1);
        check("after_rst_cnt", int'(prime_cnt), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
